// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide op encodings and the
// multiply/divide unit state enum, reused by the controller and stall logic.
package mips_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } md_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-iteration shift-add multiplier / restoring divider holding the
// architectural HI/LO registers.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_t        dbg_state
);

    // Handshake: start is a single-cycle request honoured only when the state is
    // IDLE (including the cycle done is high); busy covers the iterative work and
    // done is a one-cycle completion pulse, with div_by_zero qualified by done.

    md_state_t          state;
    logic               is_mul;
    logic               sign_a;
    logic               sign_b;
    logic               dz_pending;
    logic               fix_done;
    logic [4:0]         cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic               op_is_div;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic               add_cin;
    logic [WIDTH+1:0]   sum;
    logic               rem_ge;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = op_signed & operand_a[WIDTH-1];
    assign b_neg     = op_signed & operand_b[WIDTH-1];
    assign dbg_state = state;

    // One 33-bit adder: multiply adds the gated multiplicand into the upper
    // half, divide subtracts the divisor from the shifted partial remainder.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (is_mul) begin
            add_x = {1'b0, acc[2*WIDTH-1:WIDTH]};
            add_y = mag_b[0] ? {1'b0, mag_a} : '0;
        end else begin
            add_x   = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
            add_y   = ~{1'b0, mag_b};
            add_cin = 1'b1;
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    assign rem_ge = sum[WIDTH+1];
    assign q_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            is_mul      <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz_pending  <= 1'b0;
            fix_done    <= 1'b0;
            cnt         <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == MD_MTHI) begin
                            hi <= operand_a;
                        end else if (op == MD_MTLO) begin
                            lo <= operand_a;
                        end else if (!op[2]) begin
                            is_mul   <= !op_is_div;
                            sign_a   <= a_neg;
                            sign_b   <= b_neg;
                            mag_a    <= a_neg ? -operand_a : operand_a;
                            mag_b    <= b_neg ? -operand_b : operand_b;
                            acc      <= '0;
                            cnt      <= 5'd31;
                            fix_done <= 1'b0;
                            // A zero divisor bypasses CALC and reports from SIGN.
                            if (op_is_div && (operand_b == '0)) begin
                                dz_pending <= 1'b1;
                                state      <= SIGN;
                            end else begin
                                dz_pending <= 1'b0;
                                state      <= CALC;
                            end
                        end
                    end
                end
                CALC: begin
                    busy <= 1'b1;
                    if (is_mul) begin
                        acc   <= {sum[WIDTH:0], acc[WIDTH-1:1]};
                        mag_b <= mag_b >> 1;
                    end else begin
                        acc[2*WIDTH-1:WIDTH] <= rem_ge ? sum[WIDTH-1:0] : add_x[WIDTH-1:0];
                        acc[WIDTH-1:0]       <= {acc[WIDTH-2:0], rem_ge};
                        mag_a                <= mag_a << 1;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == '0) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    if (dz_pending) begin
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        dz_pending  <= 1'b0;
                        state       <= IDLE;
                    end else if (!fix_done) begin
                        // Sign correction is registered first to keep it off the HI/LO write path.
                        acc      <= is_mul ? ((sign_a ^ sign_b) ? -acc : acc) : {r_fix, q_fix};
                        fix_done <= 1'b1;
                    end else begin
                        hi    <= acc[2*WIDTH-1:WIDTH];
                        lo    <= acc[WIDTH-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic
// reference of MULT/MULTU/DIV/DIVU/MTHI/MTLO semantics and handshake timing.
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_t   dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result as {hi, lo} from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, qq, rr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (o)
            MD_MULTU: r = ua * ub;
            MD_MULT:  r = sa * sb;
            MD_DIVU: begin
                uq = ua / ub;
                ur = ua % ub;
                r  = {ur[31:0], uq[31:0]};
            end
            MD_DIV: begin
                qq = sa / sb;
                rr = sa % sb;
                r  = {rr[31:0], qq[31:0]};
            end
            default: r = {m_hi, m_lo};
        endcase
        return r;
    endfunction

    // Issues a MULT/DIV request and follows it to done; returns in the done cycle.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int intrude_at);
        logic [63:0] r;
        logic        exp_dz;
        int          k, busy_cyc, exp_lat, exp_busy;
        exp_dz = ((o == MD_DIV) || (o == MD_DIVU)) && (b == 32'd0);
        if (exp_dz) begin
            r        = {m_hi, m_lo};
            exp_lat  = 1;
            exp_busy = 0;
        end else begin
            r        = ref_md(o, a, b);
            exp_lat  = 34;
            exp_busy = 33;
        end
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        op        = 3'($urandom_range(0, 7));
        operand_a = $urandom;
        operand_b = $urandom;
        k         = 0;
        busy_cyc  = 0;
        while (!done && k < 100) begin
            if (busy) busy_cyc++;
            if (k == 16 && !exp_dz) begin
                check("hold_hi", 64'(hi), 64'(m_hi));
                check("hold_lo", 64'(lo), 64'(m_lo));
            end
            if (k == intrude_at) begin
                start     = 1'b1;
                op        = MD_MTHI;
                operand_a = 32'h0000_AAAA;
            end
            tick();
            start = 1'b0;
            k++;
        end
        m_hi = r[63:32];
        m_lo = r[31:0];
        check("latency", 64'(k), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
        check("busy_at_done", 64'(busy), 64'(0));
        check("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    endtask

    // MTHI/MTLO or a no-op code: takes effect on the start edge, no handshake.
    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        op        = o;
        operand_a = a;
        operand_b = $urandom;
        start     = 1'b1;
        tick();
        start = 1'b0;
        if (o == MD_MTHI) m_hi = a;
        if (o == MD_MTLO) m_lo = a;
        check("mt_hi", 64'(hi), 64'(m_hi));
        check("mt_lo", 64'(lo), 64'(m_lo));
        check("mt_busy", 64'(busy), 64'(0));
        check("mt_done", 64'(done), 64'(0));
    endtask

    initial begin
        logic        seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        reset     = 1'b0;
        start     = 1'b0;
        op        = '0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) tick();
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_by_zero), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b1;
        tick();

        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("multu_const_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_const_lo", 64'(lo), 64'h0000_0000_0000_0001);
        run_md(MD_MULT, 32'hFFFF_FFFD, 32'd7, -1);
        check("mult_const_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        run_md(MD_DIVU, 32'd100, 32'd7, -1);
        check("divu_const_lo", 64'(lo), 64'h0000_0000_0000_000E);
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        check("div_const_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
        tick();

        mt(MD_MTHI, 32'h0000_1234);
        mt(MD_MTLO, 32'h0000_5678);
        run_md(MD_DIV, 32'd5, 32'd0, -1);
        tick();
        check("dz_done_pulse", 64'(done), 64'(0));
        check("dz_flag_clear", 64'(div_by_zero), 64'(0));

        // Start while busy is ignored; a start in the done cycle is accepted.
        run_md(MD_MULTU, 32'd2, 32'd3, 5);
        check("intrude_hi", 64'(hi), 64'(0));
        run_md(MD_MULTU, 32'd7, 32'd9, -1);
        tick();
        check("done_pulse", 64'(done), 64'(0));

        // Reset in the middle of an operation.
        run_md(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, -1);
        tick();
        op        = MD_MULTU;
        operand_a = 32'd2;
        operand_b = 32'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_hi", 64'(hi), 64'(0));
        check("mid_rst_lo", 64'(lo), 64'(0));
        repeat (2) tick();
        reset = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("no_done_after_rst", 64'(seen), 64'(0));
        run_md(MD_MULTU, 32'd2, 32'd3, -1);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (ro[2]) mt(ro, ra);
            else       run_md(ro, ra, rb, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
